// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_e;

  localparam logic [1:0] WB_CTL_BUBBLE = 2'b00;
  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         WAIT_CNT_W    = 8;

  // Write-back control as seen by MEM/WB: a bubble kills register and memory writes.
  function automatic logic [1:0] wb_ctl_after(input logic bubble, input logic [1:0] wb_ctl);
    logic [1:0] r;
    if (bubble) begin
      r = WB_CTL_BUBBLE;
    end else begin
      r = wb_ctl;
    end
    return r;
  endfunction

  // Odd parity over a register index, used by checkers guarding the hazard inputs.
  function automatic logic reg_idx_parity(input logic [4:0] idx);
    return ^idx;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-source inputs and pipeline-register controls of the hazard controller.
interface pipeline_hazard_controller_if #(
  parameter int STALL_CNT_W = 16
);

  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic                   idex_mem_read;
  logic [4:0]             idex_rt;
  logic                   branch_taken_ex;
  logic                   mem_access;
  logic                   dmem_ready;

  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic                   idex_flush;
  logic                   exmem_hold;
  logic                   memwb_bubble;
  logic                   mem_timeout;
  logic [STALL_CNT_W-1:0] stall_count;

  // Pipeline side: reports hazard sources, consumes the controls.
  modport master (
    output id_rs, id_rt, idex_mem_read, idex_rt, branch_taken_ex, mem_access, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, memwb_bubble,
           mem_timeout, stall_count
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, idex_mem_read, idex_rt, branch_taken_ex, mem_access, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, memwb_bubble,
           mem_timeout, stall_count
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds the ID instruction.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  logic rs_match_s;
  logic rt_match_s;

  // $zero is hard-wired, so a load targeting it never creates a dependence.
  always_comb begin
    rs_match_s = (ex_rt == id_rs);
    rt_match_s = (ex_rt == id_rt);
    if (mem_read && (ex_rt != REG_ZERO)) begin
      load_use = rs_match_s || rt_match_s;
    end else begin
      load_use = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and memory-wait freeze,
// with a memory-wait timeout into HALT and a saturating stall-cycle counter.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_hazard_controller_if.slave  hz
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(TIMEOUT_CYCLES);

  hz_state_e              state_q,       state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q,    wait_cnt_d;
  logic                   mem_timeout_q, mem_timeout_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  logic load_use_s;
  logic mem_busy_s;
  logic pc_write_s;
  logic ifid_write_s;
  logic ifid_flush_s;
  logic idex_flush_s;
  logic exmem_hold_s;
  logic memwb_bubble_s;

  load_use_detect u_load_use (
    .mem_read (hz.idex_mem_read),
    .ex_rt    (hz.idex_rt),
    .id_rs    (hz.id_rs),
    .id_rt    (hz.id_rt),
    .load_use (load_use_s)
  );

  assign mem_busy_s = hz.mem_access && !hz.dmem_ready;

  // Control outputs and next-state; a memory freeze outranks branches because EX is held.
  always_comb begin
    pc_write_s     = 1'b0;
    ifid_write_s   = 1'b0;
    ifid_flush_s   = 1'b0;
    idex_flush_s   = 1'b0;
    exmem_hold_s   = 1'b0;
    memwb_bubble_s = 1'b0;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;

    if (reset) begin
      state_d    = RUN;
      wait_cnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy_s) begin
            exmem_hold_s   = 1'b1;
            memwb_bubble_s = 1'b1;
            state_d        = MEM_WAIT;
            wait_cnt_d     = WAIT_CNT_W'(1);
          end else if (hz.branch_taken_ex) begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (load_use_s) begin
            idex_flush_s = 1'b1;
          end else begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
          end
        end
        MEM_WAIT: begin
          exmem_hold_s = 1'b1;
          // A mem_access drop without ready still counts as waiting.
          if (hz.mem_access && hz.dmem_ready) begin
            memwb_bubble_s = 1'b0;
            state_d        = RUN;
            wait_cnt_d     = '0;
          end else if (wait_cnt_q >= TIMEOUT_LIM) begin
            memwb_bubble_s = 1'b1;
            state_d        = HALT;
            mem_timeout_d  = 1'b1;
          end else begin
            memwb_bubble_s = 1'b1;
            wait_cnt_d     = wait_cnt_q + WAIT_CNT_W'(1);
          end
        end
        HALT: begin
          exmem_hold_s   = 1'b1;
          memwb_bubble_s = 1'b1;
        end
        default: begin
          exmem_hold_s   = 1'b1;
          memwb_bubble_s = 1'b1;
          state_d        = RUN;
          wait_cnt_d     = '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    if (!reset && !pc_write_s && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State and counters; reset may arrive mid-wait and must abort it at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.pc_write     = pc_write_s;
  assign hz.ifid_write   = ifid_write_s;
  assign hz.ifid_flush   = ifid_flush_s;
  assign hz.idex_flush   = idex_flush_s;
  assign hz.exmem_hold   = exmem_hold_s;
  assign hz.memwb_bubble = memwb_bubble_s;
  assign hz.mem_timeout  = mem_timeout_q;
  assign hz.stall_count  = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with TIMEOUT_CYCLES=4 and a 4-bit stall counter.
module tb_pipeline_hazard_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pipeline_hazard_controller_if #(.STALL_CNT_W(4)) hz_if ();

  pipeline_hazard_controller #(
    .TIMEOUT_CYCLES (4),
    .STALL_CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz_if.id_rs           = 5'd0;
    hz_if.id_rt           = 5'd0;
    hz_if.idex_mem_read   = 1'b0;
    hz_if.idex_rt         = 5'd0;
    hz_if.branch_taken_ex = 1'b0;
    hz_if.mem_access      = 1'b0;
    hz_if.dmem_ready      = 1'b0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    n_checks++;
    if ({hz_if.pc_write, hz_if.ifid_write, hz_if.ifid_flush, hz_if.idex_flush,
         hz_if.exmem_hold, hz_if.memwb_bubble, hz_if.mem_timeout} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 0000000", {hz_if.pc_write, hz_if.ifid_write,
               hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_hold, hz_if.memwb_bubble,
               hz_if.mem_timeout});
    end
    n_checks++;
    if (hz_if.stall_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d expected 0", hz_if.stall_count);
    end
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({hz_if.pc_write, hz_if.ifid_write, hz_if.idex_flush} !== 3'b110) begin
      n_fail++;
      $display("FAIL run_idle: got %b expected 110", {hz_if.pc_write, hz_if.ifid_write, hz_if.idex_flush});
    end
    tick();
  endtask

  task automatic test_load_use();
    hz_if.idex_mem_read = 1'b1;
    hz_if.idex_rt       = 5'd5;
    hz_if.id_rs         = 5'd5;
    #1;
    n_checks++;
    if ({hz_if.pc_write, hz_if.ifid_write, hz_if.idex_flush, hz_if.ifid_flush} !== 4'b0010) begin
      n_fail++;
      $display("FAIL lu_rs_stall: got %b expected 0010", {hz_if.pc_write, hz_if.ifid_write,
               hz_if.idex_flush, hz_if.ifid_flush});
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (hz_if.pc_write !== 1'b1 || hz_if.stall_count !== 4'd1) begin
      n_fail++;
      $display("FAIL lu_resume: got pc_write=%b cnt=%0d expected 1 and 1", hz_if.pc_write, hz_if.stall_count);
    end
    // rt operand match
    hz_if.idex_mem_read = 1'b1;
    hz_if.idex_rt       = 5'd7;
    hz_if.id_rs         = 5'd3;
    hz_if.id_rt         = 5'd7;
    #1;
    n_checks++;
    if ({hz_if.pc_write, hz_if.idex_flush} !== 2'b01) begin
      n_fail++;
      $display("FAIL lu_rt_stall: got %b expected 01", {hz_if.pc_write, hz_if.idex_flush});
    end
    tick();
    // $zero destination never stalls
    hz_if.idex_rt = 5'd0;
    hz_if.id_rs   = 5'd0;
    hz_if.id_rt   = 5'd0;
    #1;
    n_checks++;
    if ({hz_if.pc_write, hz_if.ifid_write, hz_if.idex_flush} !== 3'b110) begin
      n_fail++;
      $display("FAIL lu_zero: got %b expected 110", {hz_if.pc_write, hz_if.ifid_write, hz_if.idex_flush});
    end
    tick();
    clear_inputs();
    n_checks++;
    if (hz_if.stall_count !== 4'd2) begin
      n_fail++;
      $display("FAIL lu_count: got %0d expected 2", hz_if.stall_count);
    end
  endtask

  task automatic test_branch();
    hz_if.branch_taken_ex = 1'b1;
    hz_if.idex_mem_read   = 1'b1;
    hz_if.idex_rt         = 5'd9;
    hz_if.id_rs           = 5'd9;
    #1;
    n_checks++;
    if ({hz_if.pc_write, hz_if.ifid_write, hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_hold}
        !== 5'b11110) begin
      n_fail++;
      $display("FAIL branch_ctl: got %b expected 11110", {hz_if.pc_write, hz_if.ifid_write,
               hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_hold});
    end
    tick();
    clear_inputs();
    n_checks++;
    if (hz_if.stall_count !== 4'd2) begin
      n_fail++;
      $display("FAIL branch_count: got %0d expected 2", hz_if.stall_count);
    end
  endtask

  task automatic test_mem_wait();
    logic [3:0] bubble_exp;
    bubble_exp = 4'b1110;
    hz_if.mem_access      = 1'b1;
    hz_if.dmem_ready      = 1'b0;
    hz_if.branch_taken_ex = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hz_if.dmem_ready = (i == 3);
      #1;
      n_checks++;
      if ({hz_if.pc_write, hz_if.ifid_write, hz_if.ifid_flush, hz_if.idex_flush,
           hz_if.exmem_hold, hz_if.memwb_bubble} !== {5'b00001, bubble_exp[3-i]}) begin
        n_fail++;
        $display("FAIL mem_wait_c%0d: got %b expected %b", i, {hz_if.pc_write, hz_if.ifid_write,
                 hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_hold, hz_if.memwb_bubble},
                 {5'b00001, bubble_exp[3-i]});
      end
      tick();
    end
    clear_inputs();
    #1;
    n_checks++;
    if (hz_if.pc_write !== 1'b1 || hz_if.exmem_hold !== 1'b0 || hz_if.stall_count !== 4'd6) begin
      n_fail++;
      $display("FAIL mem_wait_exit: got pc_write=%b hold=%b cnt=%0d expected 1 0 6",
               hz_if.pc_write, hz_if.exmem_hold, hz_if.stall_count);
    end
  endtask

  task automatic test_ready_beats_timeout();
    pulse_reset();
    hz_if.mem_access = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    hz_if.dmem_ready = 1'b1;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (hz_if.mem_timeout !== 1'b0 || hz_if.pc_write !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wins: got timeout=%b pc_write=%b expected 0 1", hz_if.mem_timeout, hz_if.pc_write);
    end
  endtask

  task automatic test_timeout();
    pulse_reset();
    hz_if.mem_access = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (hz_if.mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got %b expected 0", hz_if.mem_timeout);
    end
    tick();
    n_checks++;
    if (hz_if.mem_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_set: got %b expected 1", hz_if.mem_timeout);
    end
    for (int i = 0; i < 20; i++) begin
      hz_if.dmem_ready = (i >= 10);
      #1;
      n_checks++;
      if ({hz_if.pc_write, hz_if.ifid_write, hz_if.exmem_hold, hz_if.memwb_bubble, hz_if.mem_timeout}
          !== 5'b00111) begin
        n_fail++;
        $display("FAIL halt_c%0d: got %b expected 00111", i, {hz_if.pc_write, hz_if.ifid_write,
                 hz_if.exmem_hold, hz_if.memwb_bubble, hz_if.mem_timeout});
      end
      tick();
    end
    n_checks++;
    if (hz_if.stall_count !== 4'd15) begin
      n_fail++;
      $display("FAIL halt_count: got %0d expected 15", hz_if.stall_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    pulse_reset();
    hz_if.mem_access = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({hz_if.pc_write, hz_if.ifid_write, hz_if.ifid_flush, hz_if.idex_flush,
         hz_if.exmem_hold, hz_if.memwb_bubble, hz_if.mem_timeout} !== 7'b0 ||
        hz_if.stall_count !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: got ctl=%b cnt=%0d expected 0000000 0", {hz_if.pc_write,
               hz_if.ifid_write, hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_hold,
               hz_if.memwb_bubble, hz_if.mem_timeout}, hz_if.stall_count);
    end
    #1;
    clear_inputs();
    reset = 1'b0;
    tick();
    n_checks++;
    if (hz_if.pc_write !== 1'b1 || hz_if.exmem_hold !== 1'b0 || hz_if.stall_count !== 4'd0) begin
      n_fail++;
      $display("FAIL post_reset_run: got pc_write=%b hold=%b cnt=%0d expected 1 0 0",
               hz_if.pc_write, hz_if.exmem_hold, hz_if.stall_count);
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    hz_if.idex_mem_read = 1'b1;
    hz_if.idex_rt       = 5'd12;
    hz_if.id_rt         = 5'd12;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (hz_if.stall_count !== 4'd10) begin
      n_fail++;
      $display("FAIL sat_mid: got %0d expected 10", hz_if.stall_count);
    end
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (hz_if.stall_count !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_end: got %0d expected 15", hz_if.stall_count);
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_ready_beats_timeout();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
